// File: rtl/seg_scan_disp_if.sv
// Bus bundle for seg_scan_disp: capture inputs, live display controls and scanned outputs.
// master = display owner (CPU side), slave = the scanner itself.
interface seg_scan_disp_if #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DATA_W = 32
) ();
  localparam int unsigned SEL_W = $clog2(DIGITS);

  logic [DATA_W-1:0] data;
  logic              load;
  logic              mode;
  logic              blank_lz;
  logic [DIGITS-1:0] dp;
  logic [7:0]        seg;
  logic [SEL_W-1:0]  del;
  logic              busy;
  logic              ovf;

  modport master (
    output data, load, mode, blank_lz, dp,
    input  seg, del, busy, ovf
  );

  modport slave (
    input  data, load, mode, blank_lz, dp,
    output seg, del, busy, ovf
  );
endinterface

// File: rtl/seg_scan_disp.sv
// Multi-digit seven-segment scanner with hex capture and optional sequential decimal conversion.
// Define SEG_DEC_MODE_EN to build in the double-dabble converter; otherwise every capture is hex.
module seg_scan_disp #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  seg_scan_disp_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(DIGITS);
  localparam int unsigned PRE_W = $clog2(REFRESH_DIV);
  localparam int unsigned BUF_W = 4 * DIGITS;

  function automatic logic [6:0] seg_map(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'h0:    pat = 7'h3F;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5B;
      4'h3:    pat = 7'h4F;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6D;
      4'h6:    pat = 7'h7D;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h6F;
      4'hA:    pat = 7'h77;
      4'hB:    pat = 7'h7C;
      4'hC:    pat = 7'h39;
      4'hD:    pat = 7'h5E;
      4'hE:    pat = 7'h7B;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

  logic [BUF_W-1:0] buf_q, buf_d;
  logic             ovf_q, ovf_d;
  logic             busy;
  logic [BUF_W-1:0] hex_buf;
  logic             hex_ovf;

  // Shifting past the width yields zero, so narrow inputs never flag overflow.
  assign hex_buf = BUF_W'(bus.data);
  assign hex_ovf = (bus.data >> BUF_W) != '0;

`ifdef SEG_DEC_MODE_EN
  localparam int unsigned BCD_N = DATA_W / 3 + 1;
  localparam int unsigned BCD_W = 4 * BCD_N;
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StConv = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BUF_W-1:0] dec_buf;
  logic             dec_ovf;

  assign dec_buf = BUF_W'(bcd_q);
  assign dec_ovf = (bcd_q >> BUF_W) != '0;
  assign busy    = (state_q != StIdle);

  // Add-3 correction on every BCD digit before each shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < int'(BCD_N); k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (bus.load) begin
          if (bus.mode) begin
            state_d = StConv;
            shift_d = bus.data;
            bcd_d   = '0;
            cnt_d   = '0;
          end else begin
            buf_d = hex_buf;
            ovf_d = hex_ovf;
          end
        end
      end
      StConv: begin
        bcd_d   = BCD_W'({bcd_adj, shift_q[DATA_W-1]});
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        buf_d   = dec_buf;
        ovf_d   = dec_ovf;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = bus.mode;
  assign busy        = 1'b0;

  always_comb begin
    buf_d = buf_q;
    ovf_d = ovf_q;
    if (bus.load) begin
      buf_d = hex_buf;
      ovf_d = hex_ovf;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
      ovf_q <= ovf_d;
    end
  end

  logic [PRE_W-1:0] presc_q;
  logic [SEL_W-1:0] del_q, del_nxt;
  logic [7:0]       seg_q, seg_d;
  logic             tick;
  logic             all_zero;
  logic             blank;
  int               idx;

  assign tick    = (presc_q == PRE_W'(REFRESH_DIV - 1));
  assign del_nxt = (del_q == SEL_W'(DIGITS - 1)) ? '0 : del_q + 1'b1;

  // Pattern is built for the digit about to be selected so seg and del switch together.
  always_comb begin
    idx      = int'(del_nxt);
    all_zero = 1'b1;
    for (int j = 0; j < int'(DIGITS); j++) begin
      if (j >= idx && buf_q[4*j +: 4] != 4'h0) begin
        all_zero = 1'b0;
      end
    end
    blank = bus.blank_lz && (idx != 0) && all_zero;
    seg_d = {bus.dp[idx], blank ? 7'h00 : seg_map(buf_q[4*idx +: 4])};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
      del_q   <= '0;
      seg_q   <= 8'h00;
    end else if (tick) begin
      presc_q <= '0;
      del_q   <= del_nxt;
      seg_q   <= seg_d;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  assign bus.seg  = seg_q;
  assign bus.del  = del_q;
  assign bus.busy = busy;
  assign bus.ovf  = ovf_q;
endmodule

// File: doc/seg_scan_disp.md
# seg_scan_disp

Parametrised multi-digit seven-segment scanner for the board display. It latches a result word from the CPU, a write-back value or a register probe. It then time-multiplexes the digits onto one shared segment bus. Hex or decimal rendering is selectable at run time, with sequential binary-to-BCD conversion, leading-zero blanking, per-digit decimal points and an overflow flag.

## Interface
- `DIGITS`, 4: number of digits scanned (2..8).
- `DATA_W`, 32: width of the input value.
- `REFRESH_DIV`, 50000: clk cycles each digit is held (≥2).
- `SEL_W`, `$clog2(DIGITS)`: width of the digit index (derived).

Ports:
- `clk`  in  1  system clock. One clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `data`  in  DATA_W  value to display. Sampled only on an accepted `load`.
- `load`  in  1  single-cycle capture strobe.
- `mode`  in  1  0 = hex, 1 = unsigned decimal. Sampled with `load`.
- `blank_lz`  in  1  1 = blank leading zero digits. Live input.
- `dp`  in  DIGITS  decimal point per digit; bit i drives `seg[7]` on digit i. Live input.
- `seg`  out  8  segment pattern, active-high; bit 7 = decimal point.
- `del`  out  SEL_W  index of the active digit; 0 = least significant.
- `busy`  out  1  decimal conversion in progress.
- `ovf`  out  1  last captured value does not fit in DIGITS digits.

## Operation
- **Digit buffer.** DIGITS 4-bit codes, cleared by reset. The buffer changes only when a capture completes.
- **Hex capture.** On `load` with `mode`=0 and `busy`=0:
  - digit i ← `data[4i+3:4i]`;
  - `ovf` ← OR of `data` bits at and above 4·DIGITS (0 if DATA_W ≤ 4·DIGITS).
- **Decimal capture.** On `load` with `mode`=1 and `busy`=0, the converter starts:
  - Method is double-dabble, one input bit per cycle, MSB first.
  - The internal BCD register holds DATA_W/3+1 digits.
  - FSM states: IDLE → CONV (DATA_W cycles) → DONE (1 cycle) → IDLE.
  - In DONE: buffer ← low DIGITS BCD digits; `ovf` ← any higher BCD digit ≠ 0.
- **`load` while `busy`=1** is ignored; no queuing.
- **Scan.**
  - A prescaler counts 0..REFRESH_DIV-1.
  - On terminal count, the digit index advances, wrapping DIGITS-1 → 0.
  - `del` and `seg` are registered and update together on that same edge.
- **Segment map (0..F):** 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 7B 71. Blank = 00.
- **Leading-zero blanking.** Digit i (i>0) is blank when `blank_lz`=1 and digits i..DIGITS-1 are all 0. Digit 0 is never blanked.
- **Decimal point.** `seg[7]` = `dp[i]`, including on blanked digits.

## Timing
- **Reset values:** `seg`=8'h00, `del`=0, `busy`=0, `ovf`=0, buffer=0, prescaler=0, FSM=IDLE.
  - Reset asserted mid-conversion aborts it. The buffer stays zero.
- **Hex latency:** buffer and `ovf` are valid 1 cycle after `load`. `busy` never asserts.
- **Decimal busy window:**
  - `busy` rises the cycle after `load`.
  - `busy` stays high DATA_W+1 cycles and falls on the same edge that updates the buffer and `ovf`.
- **Display refresh:**
  - The first `seg` update after reset occurs REFRESH_DIV cycles later, showing digit 1.
  - A new buffer value appears at the next scan tick of each digit.
- **Simultaneous events:** a capture and a scan tick on the same edge is allowed. The tick renders the old buffer; there is no glitch requirement beyond that.
- **Full scan period:** DIGITS·REFRESH_DIV cycles.

## Configuration
- `SEG_DEC_MODE_EN` defined: the decimal converter and FSM are compiled in, and `mode` behaves as above.
- `SEG_DEC_MODE_EN` not defined:
  - the converter is removed;
  - `mode` is ignored and every capture is hex;
  - `busy` is tied to 0.

## Test plan
All scenarios use DIGITS=4, DATA_W=32, REFRESH_DIV=4, SEG_DEC_MODE_EN defined, unless noted.
- **Reset:** assert `rst`=0 for 3 cycles, then release → `seg`=00, `del`=0, `busy`=0, `ovf`=0. First tick at cycle 4 gives `del`=1, `seg`=3F.
- **Hex scan:** load 32'h0000_1A2F in hex → over the scan, `del` 0/1/2/3 shows `seg` 71/5B/77/06, each held 4 cycles, `ovf`=0. Repeat with 32'h0001_0000 → `ovf`=1, all digits 3F.
- **Decimal conversion:** load 1234 in decimal → `busy` high 33 cycles, then digits 0..3 show 66/4F/5B/06, `ovf`=0.
- **Decimal overflow:** load 12345 in decimal → `ovf`=1, display reads 2345 (6D 66 4F 5B). A `load` of 7 issued during `busy` is ignored.
- **Blanking and decimal point:** hex 32'h5 with `blank_lz`=1 and `dp`=4'b0100 → `del`0=6D, `del`1=00, `del`2=80, `del`3=00. Value 0 → `del`0=3F, others blank.
- **Macro off:** with SEG_DEC_MODE_EN undefined, `mode`=1 load of 1234 → hex digits 2 D 4 0 (5B 5E 66 3F), `busy` stays 0.
